// File: rtl/bus_dup_monitor.sv
`default_nettype none
// ============================================================================
// Module      : bus_dup_monitor
// Description : Per-channel duplicate-word / broken-increment detector for the
//               DMA bus with saturating error counters and an armable trigger
//               that captures the first offending word.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_dup_monitor #(
    parameter int NCH  = 2,
    parameter int DW   = 32,
    parameter int CNTW = 16,
    parameter int CHW  = 4
) (
    input  logic                wb_clk_2x,
    input  logic                rst,
    input  logic [NCH-1:0]      valid,
    input  logic [NCH*DW-1:0]   data,
    input  logic [NCH-1:0]      mode,
    input  logic [NCH-1:0]      trig_mask,
    input  logic                arm,
    input  logic                clr,
    output logic [NCH-1:0]      err_flag,
    output logic [NCH*CNTW-1:0] err_count,
    output logic                armed,
    output logic                trigger,
    output logic [CHW-1:0]      trig_ch,
    output logic [DW-1:0]       trig_data,
    output logic [DW-1:0]       trig_prev
);

    localparam logic [DW-1:0] C_ONE = {{(DW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [NCH-1:0]      r_valid;
    logic [NCH-1:0]      r_mode;
    logic [NCH*DW-1:0]   r_data;
    logic [NCH-1:0]      r_have_prev;
    // r_prev holds the latest word; r_prev2 the word before it. In the cycle
    // err_flag is high they are the offending word and its comparand.
    logic [DW-1:0]       r_prev  [NCH];
    logic [DW-1:0]       r_prev2 [NCH];
    logic [NCH-1:0]      w_err;

    logic [NCH-1:0]      w_hit;
    logic [CHW-1:0]      w_sel_ch;
    logic [DW-1:0]       w_sel_data;
    logic [DW-1:0]       w_sel_prev;
    logic                w_capture;

    // Input retiming stage; only reset discards an in-flight word.
    always_ff @(posedge wb_clk_2x) begin
        if (rst) begin
            r_valid <= '0;
            r_mode  <= '0;
            r_data  <= '0;
        end else begin
            r_valid <= valid;
            r_mode  <= mode;
            r_data  <= data;
        end
    end

    // Per-channel error detection against the previous word on that channel.
    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chk
            logic [DW-1:0] w_cur;
            assign w_cur    = r_data[c*DW +: DW];
            assign w_err[c] = r_valid[c] & r_have_prev[c] &
                              (r_mode[c] ? (w_cur != (r_prev[c] + C_ONE))
                                         : (w_cur == r_prev[c]));
        end
    endgenerate

    // History, error pulses and saturating counters for every channel.
    always_ff @(posedge wb_clk_2x) begin
        if (rst) begin
            r_have_prev <= '0;
            err_flag    <= '0;
            err_count   <= '0;
            for (int c = 0; c < NCH; c++) begin
                r_prev[c]  <= '0;
                r_prev2[c] <= '0;
            end
        end else if (clr) begin
            r_have_prev <= '0;
            err_flag    <= '0;
            err_count   <= '0;
        end else begin
            err_flag <= w_err;
            for (int c = 0; c < NCH; c++) begin
                if (r_valid[c]) begin
                    r_prev2[c]     <= r_prev[c];
                    r_prev[c]      <= r_data[c*DW +: DW];
                    r_have_prev[c] <= 1'b1;
                end
                if (w_err[c] && (err_count[c*CNTW +: CNTW] != {CNTW{1'b1}})) begin
                    err_count[c*CNTW +: CNTW] <= err_count[c*CNTW +: CNTW] + 1'b1;
                end
            end
        end
    end

    // Lowest-index qualifying channel wins the capture.
    always_comb begin
        w_hit      = err_flag & trig_mask;
        w_sel_ch   = '0;
        w_sel_data = '0;
        w_sel_prev = '0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (w_hit[c]) begin
                w_sel_ch   = CHW'(c);
                w_sel_data = r_prev[c];
                w_sel_prev = r_prev2[c];
            end
        end
    end

    // Trigger FSM next-state logic; clr overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE:  if (arm) w_state_nxt = ST_ARMED;
            ST_ARMED: if (|w_hit) begin
                          w_state_nxt = ST_TRIG;
                          w_capture   = 1'b1;
                      end
            ST_TRIG:  if (arm) w_state_nxt = ST_ARMED;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (clr) begin
            w_state_nxt = ST_IDLE;
            w_capture   = 1'b0;
        end
    end

    // Trigger FSM state register and capture registers.
    always_ff @(posedge wb_clk_2x) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            trig_ch   <= '0;
            trig_data <= '0;
            trig_prev <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clr) begin
                trig_ch   <= '0;
                trig_data <= '0;
                trig_prev <= '0;
            end else if (w_capture) begin
                trig_ch   <= w_sel_ch;
                trig_data <= w_sel_data;
                trig_prev <= w_sel_prev;
            end
        end
    end

    assign armed   = (r_state == ST_ARMED);
    assign trigger = (r_state == ST_TRIG);

endmodule
`default_nettype wire

// File: tb/tb_bus_dup_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_dup_monitor
// Description : Directed self-checking bench for bus_dup_monitor
//               (NCH=2, DW=32, CNTW=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_dup_monitor;

    logic        wb_clk_2x = 1'b0;
    logic        rst       = 1'b1;
    logic [1:0]  valid     = '0;
    logic [63:0] data      = '0;
    logic [1:0]  mode      = '0;
    logic [1:0]  trig_mask = '0;
    logic        arm       = 1'b0;
    logic        clr       = 1'b0;
    logic [1:0]  err_flag;
    logic [7:0]  err_count;
    logic        armed;
    logic        trigger;
    logic [3:0]  trig_ch;
    logic [31:0] trig_data;
    logic [31:0] trig_prev;

    int n_cmp = 0;
    int n_err = 0;

    bus_dup_monitor #(.NCH(2), .DW(32), .CNTW(4), .CHW(4)) dut (
        .wb_clk_2x (wb_clk_2x),
        .rst       (rst),
        .valid     (valid),
        .data      (data),
        .mode      (mode),
        .trig_mask (trig_mask),
        .arm       (arm),
        .clr       (clr),
        .err_flag  (err_flag),
        .err_count (err_count),
        .armed     (armed),
        .trigger   (trigger),
        .trig_ch   (trig_ch),
        .trig_data (trig_data),
        .trig_prev (trig_prev)
    );

    // Free-running clock.
    always #5 wb_clk_2x = ~wb_clk_2x;

    task automatic tick();
        @(posedge wb_clk_2x);
        #1;
    endtask

    task automatic put(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1);
        valid = v;
        data  = {d1, d0};
        tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Directed test sequence.
    initial begin
        tick();
        tick();
        chk("rst_flag",  64'(err_flag),  64'h0);
        chk("rst_count", 64'(err_count), 64'h0);
        chk("rst_armed", 64'(armed),     64'h0);
        chk("rst_trig",  64'(trigger),   64'h0);
        chk("rst_tch",   64'(trig_ch),   64'h0);
        chk("rst_tdata", 64'(trig_data), 64'h0);
        chk("rst_tprev", 64'(trig_prev), 64'h0);
        rst  = 1'b0;
        mode = 2'b10;
        tick();

        // Duplication on ch0
        put(2'b01, 32'h11, 32'h0);
        put(2'b01, 32'h22, 32'h0);
        put(2'b01, 32'h22, 32'h0);
        chk("dup_flag_early", 64'(err_flag), 64'h0);
        put(2'b01, 32'h33, 32'h0);
        chk("dup_flag", 64'(err_flag), 64'h1);
        chk("dup_count_now", 64'(err_count), 64'h01);
        put(2'b00, 32'h0, 32'h0);
        chk("dup_flag_gone", 64'(err_flag), 64'h0);
        put(2'b00, 32'h0, 32'h0);
        chk("dup_count", 64'(err_count), 64'h01);

        // Sequence wrap on ch1
        put(2'b10, 32'h0, 32'hFFFF_FFFE);
        put(2'b10, 32'h0, 32'hFFFF_FFFF);
        put(2'b10, 32'h0, 32'h0000_0000);
        chk("seq_inc", 64'(err_flag), 64'h0);
        put(2'b10, 32'h0, 32'h0000_0002);
        chk("seq_wrap", 64'(err_flag), 64'h0);
        put(2'b00, 32'h0, 32'h0);
        chk("seq_gap", 64'(err_flag), 64'h2);
        put(2'b00, 32'h0, 32'h0);
        chk("seq_count", 64'(err_count), 64'h11);

        // First word after clr is not compared
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_count", 64'(err_count), 64'h0);
        chk("clr_flag",  64'(err_flag),  64'h0);
        put(2'b01, 32'h0, 32'h0);
        put(2'b01, 32'h0, 32'h0);
        chk("first_nocmp", 64'(err_flag), 64'h0);
        put(2'b00, 32'h0, 32'h0);
        chk("second_dup", 64'(err_flag), 64'h1);
        put(2'b00, 32'h0, 32'h0);
        chk("second_count", 64'(err_count), 64'h01);

        // Trigger priority: ch0 sequence error vs ch1 duplicate, same cycle
        clr = 1'b1;
        tick();
        clr       = 1'b0;
        mode      = 2'b01;
        trig_mask = 2'b11;
        arm       = 1'b1;
        tick();
        arm = 1'b0;
        chk("arm_armed", 64'(armed), 64'h1);
        put(2'b11, 32'h10, 32'hB0);
        put(2'b11, 32'h20, 32'hB0);
        put(2'b00, 32'h0, 32'h0);
        chk("both_flag", 64'(err_flag), 64'h3);
        chk("trig_not_yet", 64'(trigger), 64'h0);
        put(2'b00, 32'h0, 32'h0);
        chk("trig_high",  64'(trigger),   64'h1);
        chk("trig_armed", 64'(armed),     64'h0);
        chk("trig_ch",    64'(trig_ch),   64'h0);
        chk("trig_data",  64'(trig_data), 64'h20);
        chk("trig_prev",  64'(trig_prev), 64'h10);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("rearm_trig",  64'(trigger),   64'h0);
        chk("rearm_armed", 64'(armed),     64'h1);
        chk("rearm_hold",  64'(trig_data), 64'h20);

        // Saturation at 15
        clr = 1'b1;
        tick();
        clr  = 1'b0;
        mode = 2'b00;
        for (int i = 0; i < 20; i++) put(2'b01, 32'h55, 32'h0);
        put(2'b00, 32'h0, 32'h0);
        put(2'b00, 32'h0, 32'h0);
        chk("sat_count", 64'(err_count), 64'h0F);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sat_clr", 64'(err_count), 64'h0);

        // clr and arm together
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("pre_coll_armed", 64'(armed), 64'h1);
        arm = 1'b1;
        clr = 1'b1;
        tick();
        arm = 1'b0;
        clr = 1'b0;
        chk("coll_armed", 64'(armed),   64'h0);
        chk("coll_trig",  64'(trigger), 64'h0);

        // Reset mid-stream
        trig_mask = 2'b00;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        put(2'b01, 32'h77, 32'h0);
        put(2'b01, 32'h77, 32'h0);
        put(2'b01, 32'h77, 32'h0);
        chk("pre_rst_flag",  64'(err_flag),  64'h1);
        chk("pre_rst_count", 64'(err_count), 64'h01);
        chk("pre_rst_armed", 64'(armed),     64'h1);
        rst   = 1'b1;
        valid = 2'b00;
        tick();
        chk("mid_rst_flag",  64'(err_flag),  64'h0);
        chk("mid_rst_count", 64'(err_count), 64'h0);
        chk("mid_rst_armed", 64'(armed),     64'h0);
        chk("mid_rst_trig",  64'(trigger),   64'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_flag", 64'(err_flag), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
